// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
//   Serialises a stereo PCM pair onto a Philips-format I2S DAC interface.
//   BCK and LRCK are derived from clk_sys; each frame carries 32 bit clocks
//   (16 per channel) with the one-BCK data delay standard I2S requires.
//   Samples enter through a single-entry pending buffer and are moved into
//   the shifting ("active") pair at the start of each frame.
//
// Parameters
//   CLK_DIV   system clocks per BCK half-period (>= 2)
//   AUDIO_DW  bits per channel (only 16 is supported)
//
// Ports
//   clk_sys   system clock, all logic on the rising edge
//   reset_n   synchronous active-low reset
//   in_left   left sample (two's complement)
//   in_right  right sample (two's complement)
//   in_valid  sample pair presented
//   in_ready  pending buffer empty
//   underrun  one-clock pulse: a frame started with no pending sample
//   I2S_BCK   bit clock
//   I2S_LRCK  word select, 0 = left, 1 = right
//   I2S_DATA  serial data, MSB first
//
// Build option
//   I2S_MUTE_ON_UNDERRUN_EN  when defined, an underrun frame is silent;
//                            otherwise the last pair is repeated.
//
// Handshake: a pair transfers on a clk_sys rising edge where in_valid and
// in_ready are both 1. in_ready is 1 exactly when the pending buffer is
// empty; it drops the clock after a transfer and rises again the clock after
// the frame load that empties the buffer. in_valid while in_ready is 0 is
// ignored, so the source must hold its pair until it is taken.
// -----------------------------------------------------------------------------
module i2s_audio_tx #(
   parameter int CLK_DIV  = 16,
   parameter int AUDIO_DW = 16
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic [AUDIO_DW-1:0] in_left,
   input  logic [AUDIO_DW-1:0] in_right,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                underrun,
   output logic                I2S_BCK,
   output logic                I2S_LRCK,
   output logic                I2S_DATA
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]    div_cnt;
   logic [4:0]          slot;
   logic [AUDIO_DW-1:0] active_l;
   logic [AUDIO_DW-1:0] active_r;
   logic [AUDIO_DW-1:0] pend_l;
   logic [AUDIO_DW-1:0] pend_r;
   logic                pend_full;

   logic       div_tc;
   logic       fall_tick;
   logic       frame_load;
   logic [4:0] slot_next;
   logic [3:0] bit_idx;
   logic       data_next;

   assign div_tc     = (div_cnt == DIV_W'(CLK_DIV - 1));
   // The cycle on which BCK is driven 1->0: the only cycle the slot,
   // LRCK and DATA move, so they are settled long before the next rise.
   assign fall_tick  = div_tc & I2S_BCK;
   assign frame_load = fall_tick & (slot == 5'd31);
   assign slot_next  = slot + 5'd1;
   assign in_ready   = ~pend_full;

   // Left bit for slot s is 16-s, right bit is 32-s; both are (-s) mod 16,
   // so a single 4-bit index serves both halves of the frame.
   assign bit_idx = ~slot_next[3:0] + 4'd1;

   always_comb begin
      data_next = 1'b0;
      if (slot_next == 5'd0) begin
         // One-bit I2S delay: slot 0 carries the LSB of the right word that
         // was shifting in the frame just ending (the value before the load).
         data_next = active_r[0];
      end else if (slot_next <= 5'd16) begin
         data_next = active_l[bit_idx];
      end else begin
         data_next = active_r[bit_idx];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         slot      <= 5'd31;
         active_l  <= '0;
         active_r  <= '0;
         pend_l    <= '0;
         pend_r    <= '0;
         pend_full <= 1'b0;
         underrun  <= 1'b0;
         I2S_BCK   <= 1'b0;
         I2S_LRCK  <= 1'b0;
         I2S_DATA  <= 1'b0;
      end else begin
         underrun <= 1'b0;

         if (div_tc) begin
            div_cnt <= '0;
            I2S_BCK <= ~I2S_BCK;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (fall_tick) begin
            slot     <= slot_next;
            I2S_LRCK <= slot_next[4];
            I2S_DATA <= data_next;
         end

         // The load only sees the buffer as it was before this edge: a pair
         // accepted on the same edge waits in pending for the next frame.
         if (frame_load) begin
            if (pend_full) begin
               active_l  <= pend_l;
               active_r  <= pend_r;
               pend_full <= 1'b0;
            end else begin
               underrun <= 1'b1;
`ifdef I2S_MUTE_ON_UNDERRUN_EN
               active_l <= '0;
               active_r <= '0;
`endif
            end
         end

         // Accept needs an empty buffer, so it never collides with a load
         // that is emptying a full one.
         if (in_valid && in_ready) begin
            pend_l    <= in_left;
            pend_r    <= in_right;
            pend_full <= 1'b1;
         end
      end
   end

endmodule
